tohost_monitor: RTL and testbench

Synthesizable end-of-test monitor that sits beside `Core` on the data-memory write port and turns a riscv-tests `tohost` store into registered pass/fail status. It snoops every store; the first write of an odd value to `TOHOST_ADDR` ends the test. A value of 1 means pass; any other odd value means fail, with the failing test number in `value >> 1`. A cycle counter, and optionally a watchdog, make the result visible to FPGA LEDs or to a bench without peeking at `pc` or `rs[3]`.

---
 rtl/tohost_pkg.sv | 20 ++
 rtl/tohost_monitor_if.sv | 16 +
 rtl/tohost_cycle_counter.sv | 38 +++
 rtl/tohost_monitor.sv | 101 ++++++++++
 tb/tb_tohost_monitor.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tohost_pkg.sv
// tohost_pkg: shared types and constants for the tohost end-of-test monitor.
//   state_e          - monitor state encoding (RUN=0, PASS=1, FAIL=2, TIMEOUT=3)
//   TOHOST_ADDR_DFLT - default byte address of the riscv-tests tohost word
//   TOHOST_PASS      - tohost value that signals a passing test
package tohost_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] TOHOST_ADDR_DFLT = 32'h0000_1000;
  localparam logic [DATA_W-1:0] TOHOST_PASS      = 32'h0000_0001;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } state_e;

endpackage

// File: rtl/tohost_monitor_if.sv
// tohost_monitor_if: data-memory store port as seen by the tohost monitor.
//   wr_en   - a store happens this cycle
//   wr_addr - store byte address
//   wr_data - store data, full word
// master: the core driving stores; slave: the monitor snooping them.
interface tohost_monitor_if;
  import tohost_pkg::*;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/tohost_cycle_counter.sv
// tohost_cycle_counter: saturating cycle counter with enable and synchronous clear.
//   clk   - clock
//   clr   - synchronous clear to 0 (priority over en)
//   en    - count this edge
//   count - registered count, holds at all-ones
//   hit_c - combinational: count equals LIMIT
module tohost_cycle_counter #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned LIMIT = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             hit_c
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, else increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count = count_q;
  assign hit_c = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/tohost_monitor.sv
// tohost_monitor: snoops core stores and turns the first odd write to tohost
// into sticky pass/fail status plus a cycle count.
//   clk, rst - clock and synchronous active-high reset
//   bus      - store port (tohost_monitor_if.slave)
//   done     - test ended (pass, fail or timeout), sticky
//   pass     - test ended with tohost == 1, sticky
//   fail_id  - wr_data[31:1] of the failing store, 0 unless FAIL
//   timeout  - watchdog expired before any result, sticky
//   halt     - same as done, stall/stop request for the core
//   cycles   - edges spent in RUN, saturating, frozen once done
// Build option: define TOHOST_MONITOR_WATCHDOG_EN to build the TIMEOUT state.
module tohost_monitor
  import tohost_pkg::*;
#(
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = TOHOST_ADDR_DFLT,
  parameter int unsigned       TIMEOUT_CYCLES = 5000,
  parameter int unsigned       CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  tohost_monitor_if.slave      bus,
  output logic                 done,
  output logic                 pass,
  output logic [DATA_W-2:0]    fail_id,
  output logic                 timeout,
  output logic                 halt,
  output logic [CNT_W-1:0]     cycles
);

  state_e              state_q, state_d;
  logic [DATA_W-2:0]   fail_id_q, fail_id_d;
  logic                result_wr_c;
  logic                run_c;
  logic                wd_hit_c;

  assign run_c       = (state_q == RUN);
  assign result_wr_c = bus.wr_en && (bus.wr_addr == TOHOST_ADDR) && bus.wr_data[0];

  // Counts the edges on which the state is RUN; rst restarts it from 0.
  tohost_cycle_counter #(
    .CNT_W (CNT_W),
    .LIMIT (TIMEOUT_CYCLES - 1)
  ) u_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (run_c),
    .count (cycles),
    .hit_c (wd_hit_c)
  );

`ifndef TOHOST_MONITOR_WATCHDOG_EN
  // The limit compare only feeds the watchdog, which is not built here.
  logic unused_wd_hit;
  assign unused_wd_hit = wd_hit_c;
`endif

  // Next state: only RUN reacts; a result write beats watchdog expiry.
  always_comb begin
    state_d   = state_q;
    fail_id_d = fail_id_q;
    case (state_q)
      RUN: begin
        if (result_wr_c) begin
          if (bus.wr_data == TOHOST_PASS) begin
            state_d = PASS;
          end else begin
            state_d   = FAIL;
            fail_id_d = bus.wr_data[DATA_W-1:1];
          end
        end
`ifdef TOHOST_MONITOR_WATCHDOG_EN
        else if (wd_hit_c) begin
          state_d = TIMEOUT;
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      fail_id_q <= '0;
    end else begin
      state_q   <= state_d;
      fail_id_q <= fail_id_d;
    end
  end

  assign done    = !run_c;
  assign halt    = !run_c;
  assign pass    = (state_q == PASS);
  assign fail_id = fail_id_q;
`ifdef TOHOST_MONITOR_WATCHDOG_EN
  assign timeout = (state_q == TIMEOUT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_tohost_monitor.sv
// tb_tohost_monitor: directed and randomized checks of tohost_monitor against
// an outcome-level reference model (first odd tohost write decides the result).
module tb_tohost_monitor;
  import tohost_pkg::*;

  localparam int unsigned TO_CYC = 50;
  localparam longint      MAXC   = 64'hFFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        done, pass, timeout, halt;
  logic [30:0] fail_id;
  logic [31:0] cycles;

  tohost_monitor_if bus ();

  tohost_monitor #(
    .TOHOST_ADDR    (32'h0000_1000),
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (32)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .done    (done),
    .pass    (pass),
    .fail_id (fail_id),
    .timeout (timeout),
    .halt    (halt),
    .cycles  (cycles)
  );

`ifndef TOHOST_MONITOR_WATCHDOG_EN
  logic        s_done, s_pass, s_timeout, s_halt;
  logic [30:0] s_fail_id;
  logic [3:0]  s_cycles;
  longint      m4_cycles;

  tohost_monitor #(
    .TOHOST_ADDR    (32'h0000_1000),
    .TIMEOUT_CYCLES (TO_CYC),
    .CNT_W          (4)
  ) dut_sat (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .done    (s_done),
    .pass    (s_pass),
    .fail_id (s_fail_id),
    .timeout (s_timeout),
    .halt    (s_halt),
    .cycles  (s_cycles)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: outcome of the test so far, in plain terms.
  logic        m_done, m_pass, m_timeout;
  logic [30:0] m_fail_id;
  longint      m_cycles;

  // One clock: drive the inputs, take the edge, update the model, settle.
  task automatic step(input logic en, input logic [31:0] a, input logic [31:0] d,
                      input logic r);
    longint prev;
    bus.wr_en   = en;
    bus.wr_addr = a;
    bus.wr_data = d;
    rst         = r;
    @(posedge clk);
    if (r) begin
      m_done = 0; m_pass = 0; m_timeout = 0; m_fail_id = '0; m_cycles = 0;
`ifndef TOHOST_MONITOR_WATCHDOG_EN
      m4_cycles = 0;
`endif
    end else if (!m_done) begin
      prev     = m_cycles;
      m_cycles = (m_cycles >= MAXC) ? MAXC : m_cycles + 1;
`ifndef TOHOST_MONITOR_WATCHDOG_EN
      m4_cycles = (m4_cycles >= 15) ? 15 : m4_cycles + 1;
`endif
      if (en && a == 32'h0000_1000 && d[0]) begin
        m_done = 1;
        if (d == 32'h1) m_pass = 1;
        else m_fail_id = d[31:1];
      end
`ifdef TOHOST_MONITOR_WATCHDOG_EN
      else if (prev == longint'(TO_CYC) - 1) begin
        m_done    = 1;
        m_timeout = 1;
      end
`endif
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_reset;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_1000, 32'h1, 1'b1);
    n_cmp++; if (done !== 1'b0)    begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_cmp++; if (pass !== 1'b0)    begin n_err++; $display("FAIL reset_pass got %b want 0", pass); end
    n_cmp++; if (timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout); end
    n_cmp++; if (halt !== 1'b0)    begin n_err++; $display("FAIL reset_halt got %b want 0", halt); end
    n_cmp++; if (fail_id !== 31'd0) begin n_err++; $display("FAIL reset_fail_id got %0d want 0", fail_id); end
    n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL reset_cycles got %0d want 0", cycles); end
  endtask

  task automatic test_pass;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(20);
    n_cmp++; if (done !== 1'b0)     begin n_err++; $display("FAIL pass_pre_done got %b want 0", done); end
    n_cmp++; if (cycles !== 32'd20) begin n_err++; $display("FAIL pass_pre_cycles got %0d want 20", cycles); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (done !== 1'b1)     begin n_err++; $display("FAIL pass_done got %b want 1", done); end
    n_cmp++; if (pass !== 1'b1)     begin n_err++; $display("FAIL pass_pass got %b want 1", pass); end
    n_cmp++; if (fail_id !== 31'd0) begin n_err++; $display("FAIL pass_fail_id got %0d want 0", fail_id); end
    n_cmp++; if (cycles !== 32'd21) begin n_err++; $display("FAIL pass_cycles got %0d want 21", cycles); end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h0000_1000, (i % 2 == 0) ? 32'h0000_0007 : $urandom, 1'b0);
      n_cmp++;
      if (done !== 1'b1 || pass !== 1'b1 || fail_id !== 31'd0 || cycles !== 32'd21) begin
        n_err++;
        $display("FAIL pass_hold[%0d] got done=%b pass=%b fail_id=%0d cycles=%0d want 1 1 0 21",
                 i, done, pass, fail_id, cycles);
      end
    end
  endtask

  task automatic test_fail;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(3);
    step(1'b1, 32'h0000_1000, 32'h0000_0007, 1'b0);
    n_cmp++; if (done !== 1'b1)     begin n_err++; $display("FAIL fail_done got %b want 1", done); end
    n_cmp++; if (pass !== 1'b0)     begin n_err++; $display("FAIL fail_pass got %b want 0", pass); end
    n_cmp++; if (fail_id !== 31'd3) begin n_err++; $display("FAIL fail_id got %0d want 3", fail_id); end
    n_cmp++; if (cycles !== 32'd4)  begin n_err++; $display("FAIL fail_cycles got %0d want 4", cycles); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (pass !== 1'b0 || fail_id !== 31'd3) begin
      n_err++; $display("FAIL fail_sticky got pass=%b fail_id=%0d want 0 3", pass, fail_id);
    end
  endtask

  task automatic test_ignored;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    step(1'b1, 32'h0000_1004, 32'h1, 1'b0);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_addr got done=%b want 0", done); end
    step(1'b1, 32'h0000_1000, 32'h2, 1'b0);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_even got done=%b want 0", done); end
    step(1'b0, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL ign_no_en got done=%b want 0", done); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (pass !== 1'b1 || done !== 1'b1) begin
      n_err++; $display("FAIL ign_then_pass got pass=%b done=%b want 1 1", pass, done);
    end
  endtask

`ifdef TOHOST_MONITOR_WATCHDOG_EN
  task automatic test_watchdog;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(49);
    n_cmp++; if (done !== 1'b0 || cycles !== 32'd49) begin
      n_err++; $display("FAIL wd_pre got done=%b cycles=%0d want 0 49", done, cycles);
    end
    idle(1);
    n_cmp++; if (timeout !== 1'b1 || done !== 1'b1 || pass !== 1'b0) begin
      n_err++; $display("FAIL wd_expire got timeout=%b done=%b pass=%b want 1 1 0", timeout, done, pass);
    end
    n_cmp++; if (cycles !== 32'd50) begin n_err++; $display("FAIL wd_cycles got %0d want 50", cycles); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    idle(5);
    n_cmp++; if (cycles !== 32'd50 || timeout !== 1'b1 || pass !== 1'b0) begin
      n_err++; $display("FAIL wd_hold got cycles=%0d timeout=%b pass=%b want 50 1 0", cycles, timeout, pass);
    end
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(49);
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (pass !== 1'b1 || timeout !== 1'b0 || done !== 1'b1) begin
      n_err++; $display("FAIL wd_race got pass=%b timeout=%b done=%b want 1 0 1", pass, timeout, done);
    end
  endtask
`endif

  task automatic test_reset_mid;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(5);
    step(1'b1, 32'h0000_1000, 32'h0000_0007, 1'b0);
    step(1'b1, 32'h0000_1000, 32'h1, 1'b1);
    n_cmp++; if (done !== 1'b0 || pass !== 1'b0 || fail_id !== 31'd0 || halt !== 1'b0 || timeout !== 1'b0) begin
      n_err++; $display("FAIL mid_rst got done=%b pass=%b fail_id=%0d halt=%b timeout=%b want all 0",
                        done, pass, fail_id, halt, timeout);
    end
    n_cmp++; if (cycles !== 32'd0) begin n_err++; $display("FAIL mid_rst_cycles got %0d want 0", cycles); end
    idle(1);
    n_cmp++; if (cycles !== 32'd1) begin n_err++; $display("FAIL mid_restart got %0d want 1", cycles); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (pass !== 1'b1) begin n_err++; $display("FAIL mid_pass got %b want 1", pass); end
  endtask

`ifndef TOHOST_MONITOR_WATCHDOG_EN
  task automatic test_saturation;
    step(1'b0, 32'h0, 32'h0, 1'b1);
    idle(20);
    n_cmp++; if (s_cycles !== 4'd15) begin n_err++; $display("FAIL sat_cycles got %0d want 15", s_cycles); end
    n_cmp++; if (s_done !== 1'b0 || s_timeout !== 1'b0) begin
      n_err++; $display("FAIL sat_state got done=%b timeout=%b want 0 0", s_done, s_timeout);
    end
    n_cmp++; if (cycles !== 32'd20) begin n_err++; $display("FAIL sat_wide got %0d want 20", cycles); end
    step(1'b1, 32'h0000_1000, 32'h1, 1'b0);
    n_cmp++; if (s_pass !== 1'b1 || s_halt !== 1'b1 || s_fail_id !== 31'd0 || s_cycles !== 4'd15) begin
      n_err++; $display("FAIL sat_pass got pass=%b halt=%b fail_id=%0d cycles=%0d want 1 1 0 15",
                        s_pass, s_halt, s_fail_id, s_cycles);
    end
  endtask
`endif

  task automatic test_random;
    logic        en, r;
    logic [31:0] a, d;
    for (int i = 0; i < 600; i++) begin
      r  = ($urandom_range(0, 29) == 0);
      en = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0, 1:    a = 32'h0000_1000;
        2:       a = 32'h0000_1004;
        default: a = $urandom;
      endcase
      d = $urandom;
      case ($urandom_range(0, 5))
        0:       d = 32'h1;
        1:       d = d | 32'h1;
        default: d = d & 32'hFFFF_FFFE;
      endcase
      step(en, a, d, r);
      n_cmp++;
      if (done !== m_done || halt !== m_done || pass !== m_pass || timeout !== m_timeout ||
          fail_id !== m_fail_id || cycles !== 32'(m_cycles)) begin
        n_err++;
        $display("FAIL rand[%0d] got d=%b p=%b t=%b h=%b id=%0d cyc=%0d want d=%b p=%b t=%b id=%0d cyc=%0d",
                 i, done, pass, timeout, halt, fail_id, cycles,
                 m_done, m_pass, m_timeout, m_fail_id, m_cycles);
      end
`ifndef TOHOST_MONITOR_WATCHDOG_EN
      n_cmp++;
      if (s_cycles !== 4'(m4_cycles) || s_done !== m_done || s_fail_id !== m_fail_id) begin
        n_err++;
        $display("FAIL rand_sat[%0d] got cyc=%0d done=%b id=%0d want %0d %b %0d",
                 i, s_cycles, s_done, s_fail_id, m4_cycles, m_done, m_fail_id);
      end
`endif
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    m_done = 0; m_pass = 0; m_timeout = 0; m_fail_id = '0; m_cycles = 0;
`ifndef TOHOST_MONITOR_WATCHDOG_EN
    m4_cycles = 0;
`endif
    test_reset;
    test_pass;
    test_fail;
    test_ignored;
`ifdef TOHOST_MONITOR_WATCHDOG_EN
    test_watchdog;
`else
    test_saturation;
`endif
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
